// File: rtl/md_ctrl.sv
// Sequences one multiply/divide op through the iterative unit: start pulse, operand hold, stall, writeback.
// Latency: accept at cycle 0, start pulse at cycle 1, writeback one cycle after unit_ready; div-by-zero writes back at cycle 1.
// Backpressure: stall is raised from the accept cycle until the op leaves BUSY/DRAIN; issue inputs are ignored outside IDLE.
module md_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic             issue_mult,
    input  logic             issue_div,
    input  logic [WIDTH-1:0] issue_a,
    input  logic [WIDTH-1:0] issue_b,
    input  logic [4:0]       issue_rd,
    input  logic             flush,
    input  logic             unit_ready,
    input  logic [WIDTH-1:0] unit_result,
    input  logic             unit_exc,
    output logic             ctrl_mult,
    output logic             ctrl_div,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_result,
    output logic             wb_exc,
    output logic [4:0]       wb_rd
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               is_mult_q;
    logic [4:0]         rd_q;
    logic [WIDTH-1:0]   res_q;
    logic               exc_q;
    logic [WIDTH-1:0]   hold_res;
    logic               hold_exc;
    logic [4:0]         hold_rd;

    logic               accept;
    logic               div_zero;
    logic               timeout;

    // Multiply wins when both op bits are set, so divide-by-zero only applies to a pure divide.
    assign accept   = (state == S_IDLE) & issue_valid & (issue_mult | issue_div) & ~flush;
    assign div_zero = issue_div & ~issue_mult & (issue_b == '0);
    assign timeout  = (cnt == CNT_W'(MAX_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: flush beats unit_ready beats the watchdog while BUSY.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = div_zero ? S_DONE : S_START;
                end
            end
            S_START: begin
                state_nxt = flush ? S_DRAIN : S_BUSY;
            end
            S_BUSY: begin
                if (flush) begin
                    state_nxt = S_DRAIN;
                end else if (unit_ready || timeout) begin
                    state_nxt = S_DONE;
                end
            end
            S_DRAIN: begin
                if (unit_ready || timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs: stall covers the accept cycle combinationally; wb fields show the held value except during the strobe.
    always_comb begin
        stall     = accept | (state == S_START) | (state == S_BUSY) | (state == S_DRAIN);
        ctrl_mult = (state == S_START) & is_mult_q;
        ctrl_div  = (state == S_START) & ~is_mult_q;
        wb_valid  = (state == S_DONE) & ~flush;
        wb_result = wb_valid ? res_q : hold_res;
        wb_exc    = wb_valid ? exc_q : hold_exc;
        wb_rd     = wb_valid ? rd_q  : hold_rd;
    end

    // Operand and destination capture on accept; held until the next accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a      <= '0;
            op_b      <= '0;
            rd_q      <= '0;
            is_mult_q <= 1'b0;
        end else if (accept) begin
            op_a      <= issue_a;
            op_b      <= issue_b;
            rd_q      <= issue_rd;
            is_mult_q <= issue_mult;
        end
    end

    // Watchdog counter: cleared in START, counts through BUSY and DRAIN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == S_START) begin
            cnt <= '0;
        end else if ((state == S_BUSY) || (state == S_DRAIN)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Pending result: local div-by-zero, unit result, or forced watchdog error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q <= '0;
            exc_q <= 1'b0;
        end else if (accept && div_zero) begin
            res_q <= '0;
            exc_q <= 1'b1;
        end else if ((state == S_BUSY) && !flush && unit_ready) begin
            res_q <= unit_result;
            exc_q <= unit_exc;
        end else if ((state == S_BUSY) && !flush && timeout) begin
            res_q <= '0;
            exc_q <= 1'b1;
        end
    end

    // Delivered writeback is retained so wb_* stay put between strobes, even across a flushed DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_res <= '0;
            hold_exc <= 1'b0;
            hold_rd  <= '0;
        end else if (wb_valid) begin
            hold_res <= res_q;
            hold_exc <= exc_q;
            hold_rd  <= rd_q;
        end
    end

endmodule
